// File: rtl/maj_chk_pkg.sv
// -----------------------------------------------------------------------------
// maj_chk_pkg
// Shared types, default sizes and helpers for the majority exhaustive checker.
//   state_t    : checker sequencing states
//   popcount() : number of set bits in a vector (up to POP_W bits wide)
//   N_IN_DEF   : default number of majority inputs
//   THRESH_DEF : default majority threshold for N_IN_DEF inputs
// -----------------------------------------------------------------------------
package maj_chk_pkg;

   localparam int N_IN_DEF   = 9;
   localparam int THRESH_DEF = 5;

   // popcount() works on a fixed-width argument so callers with any N_IN up
   // to this width can share it; narrower vectors are zero-extended.
   localparam int POP_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int unsigned popcount(input logic [POP_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_W; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/maj_exhaustive_checker_if.sv
// -----------------------------------------------------------------------------
// maj_exhaustive_checker_if
// Stimulus/response link between the checker and the majority net under test.
//   a_out : vector driven to the net, bit i feeds net input a(i+1)
//   x_in  : the net's single majority output
// Modports:
//   master : checker side (drives a_out, samples x_in)
//   slave  : majority net side (samples a_out, drives x_in)
// -----------------------------------------------------------------------------
interface maj_exhaustive_checker_if
   import maj_chk_pkg::*;
#(
   parameter int N_IN = N_IN_DEF
);

   logic [N_IN-1:0] a_out;
   logic            x_in;

   modport master (output a_out, input  x_in);
   modport slave  (input  a_out, output x_in);

endinterface

// File: rtl/maj_ref_threshold.sv
// -----------------------------------------------------------------------------
// maj_ref_threshold
// Combinational golden majority: maj = 1 when popcount(vec) >= THRESH.
// Ports:
//   vec : input vector (N_IN bits, N_IN <= 32)
//   maj : reference majority output
// -----------------------------------------------------------------------------
module maj_ref_threshold
   import maj_chk_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int THRESH = THRESH_DEF
) (
   input  logic [N_IN-1:0] vec,
   output logic            maj
);

   assign maj = (popcount(POP_W'(vec)) >= THRESH);

endmodule

// File: rtl/maj_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// maj_exhaustive_checker
// Sweeps every N_IN-bit vector into a majority net, compares the net's output
// (LATENCY cycles later) with a popcount >= THRESH reference and reports the
// mismatch count and the first failing vector.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : pulse; starts a sweep, accepted only in IDLE or DONE
//   bus (master)   : a_out vector to the net, x_in response from the net
//   busy           : high while sweeping or draining in-flight compares
//   done           : high once a sweep completes, held until the next start
//   pass           : valid with done; 1 when no mismatch was seen
//   err_count      : mismatch count, saturating at all-ones
//   first_fail     : vector of the first mismatch (0 if none)
//   first_fail_vld : first_fail holds a real mismatch
//
// Build option:
//   MAJ_CHK_STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep;
//   compares already in flight still drain for LATENCY cycles before DONE.
// -----------------------------------------------------------------------------
module maj_exhaustive_checker
   import maj_chk_pkg::*;
#(
   parameter int N_IN    = N_IN_DEF,
   parameter int THRESH  = (N_IN + 1) / 2,
   parameter int LATENCY = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   maj_exhaustive_checker_if.master bus,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [N_IN:0]           err_count,
   output logic [N_IN-1:0]         first_fail,
   output logic                    first_fail_vld
);

   localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t          state, state_nxt;
   logic            start_ok;

   // Bit N_IN of the incremented counter flags that the last vector is on
   // the bus, so the sweep never wraps back to vector 0.
   logic [N_IN:0]   vec_cnt;
   logic [N_IN:0]   vec_inc;
   logic [DW-1:0]   drain_cnt;

   logic            exp_bit;
   logic            cur_valid;
   logic            d_valid;
   logic [N_IN-1:0] d_vec;
   logic            d_exp;
   logic            mismatch;
   logic            stop_hit;
   logic [N_IN:0]   err_nxt;

   assign vec_inc   = vec_cnt + (N_IN+1)'(1);
   assign bus.a_out = vec_cnt[N_IN-1:0];
   assign cur_valid = (state == RUN);
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);

   maj_ref_threshold #(
      .N_IN   (N_IN),
      .THRESH (THRESH)
   ) u_ref (
      .vec (vec_cnt[N_IN-1:0]),
      .maj (exp_bit)
   );

   // ---------------------------------------------------------------------------
   // Compare pipeline: {valid, vec, expected} travels alongside the net's own
   // pipeline so it lines up with x_in for the same vector.
   // ---------------------------------------------------------------------------
   generate
      if (LATENCY == 0) begin : g_direct
         assign d_valid = cur_valid;
         assign d_vec   = vec_cnt[N_IN-1:0];
         assign d_exp   = exp_bit;
      end else begin : g_pipe
         logic [LATENCY-1:0] pv;
         logic [N_IN-1:0]    pvec [LATENCY];
         logic               pexp [LATENCY];

         // NOTE: sequential state uses non-blocking assignments so every stage
         // samples its neighbour's pre-edge value and the shift is order-free.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pv <= '0;
            end else begin
               pv[0] <= cur_valid;
               for (int i = 1; i < LATENCY; i++) begin
                  pv[i] <= pv[i-1];
               end
            end
         end

         // NOTE: payload stages carry no reset; only the valid bits decide
         // whether a stage is looked at, so clearing the data buys nothing.
         always_ff @(posedge clk) begin
            pvec[0] <= vec_cnt[N_IN-1:0];
            pexp[0] <= exp_bit;
            for (int i = 1; i < LATENCY; i++) begin
               pvec[i] <= pvec[i-1];
               pexp[i] <= pexp[i-1];
            end
         end

         assign d_valid = pv[LATENCY-1];
         assign d_vec   = pvec[LATENCY-1];
         assign d_exp   = pexp[LATENCY-1];
      end
   endgenerate

   assign mismatch = d_valid && (bus.x_in != d_exp);

`ifdef MAJ_CHK_STOP_ON_FAIL_EN
   assign stop_hit = mismatch;
`else
   assign stop_hit = 1'b0;
`endif

   // Saturating error counter next value, shared by the counter and by the
   // pass flag so a mismatch on the final compare is reflected in pass.
   always_comb begin
      err_nxt = err_count;
      if (mismatch && (err_count != '1)) begin
         err_nxt = err_count + (N_IN+1)'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               start_ok  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (vec_inc[N_IN] || stop_hit) begin
               state_nxt = (LATENCY > 0) ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Vector counter, drain timer and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt        <= '0;
         drain_cnt      <= '0;
         err_count      <= '0;
         first_fail     <= '0;
         first_fail_vld <= 1'b0;
         pass           <= 1'b0;
      end else if (start_ok) begin
         vec_cnt        <= '0;
         drain_cnt      <= '0;
         err_count      <= '0;
         first_fail     <= '0;
         first_fail_vld <= 1'b0;
         pass           <= 1'b0;
      end else begin
         // The counter freezes on the cycle RUN ends, so a_out keeps showing
         // the last vector driven while compares drain.
         if ((state == RUN) && (state_nxt == RUN)) begin
            vec_cnt <= vec_inc;
         end
         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
         end
         err_count <= err_nxt;
         if (mismatch && !first_fail_vld) begin
            first_fail     <= d_vec;
            first_fail_vld <= 1'b1;
         end
         if ((state != DONE) && (state_nxt == DONE)) begin
            pass <= (err_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_maj_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// tb_maj_exhaustive_checker
// Drives two checker instances side by side (LATENCY 0 and LATENCY 3), each
// connected to a behavioural majority net with configurable faults: inverted
// vectors, stuck-at-0 output, and a too-short pipeline. Expected results come
// from a sweep-level model: for every vector, what the net shows at its
// compare slot versus the true majority.
// -----------------------------------------------------------------------------
module tb_maj_exhaustive_checker;

   localparam int N  = 9;
   localparam int NV = 1 << N;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;

   always #5 clk = ~clk;

   maj_exhaustive_checker_if #(.N_IN(N)) bus0 ();
   maj_exhaustive_checker_if #(.N_IN(N)) bus3 ();

   logic         busy0, done0, pass0, ffv0;
   logic [N:0]   err0;
   logic [N-1:0] ff0;
   logic         busy3, done3, pass3, ffv3;
   logic [N:0]   err3;
   logic [N-1:0] ff3;

   maj_exhaustive_checker #(.N_IN(N), .LATENCY(0)) u_dut0 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .bus            (bus0),
      .busy           (busy0),
      .done           (done0),
      .pass           (pass0),
      .err_count      (err0),
      .first_fail     (ff0),
      .first_fail_vld (ffv0)
   );

   maj_exhaustive_checker #(.N_IN(N), .LATENCY(3)) u_dut3 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .bus            (bus3),
      .busy           (busy3),
      .done           (done3),
      .pass           (pass3),
      .err_count      (err3),
      .first_fail     (ff3),
      .first_fail_vld (ffv3)
   );

   // ---------------------------------------------------------------------------
   // Behavioural majority nets with fault injection
   // ---------------------------------------------------------------------------
   bit bad0 [NV];
   bit bad3 [NV];
   bit stuck0 = 1'b0;
   bit stuck3 = 1'b0;
   int dly3   = 3;

   function automatic bit maj(input int v);
      return $countones(v) >= 5;
   endfunction

   logic f0, f3, h1, h2, h3;

   always_comb f0 = stuck0 ? 1'b0 : (maj(int'(bus0.a_out)) ^ bad0[bus0.a_out]);
   assign bus0.x_in = f0;

   always_comb f3 = stuck3 ? 1'b0 : (maj(int'(bus3.a_out)) ^ bad3[bus3.a_out]);
   always @(posedge clk) begin
      h1 <= f3;
      h2 <= h1;
      h3 <= h2;
   end
   assign bus3.x_in = (dly3 == 2) ? h2 : h3;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Sweep-level reference: for each vector v, the net's value at v's compare
   // slot is its output for vector src(v); a too-short pipeline (2 instead of
   // 3) shows the next vector's response, and the last one repeats.
   function automatic void model(input int sel, output int cnt, output int first);
      cnt   = 0;
      first = -1;
      for (int v = 0; v < NV; v++) begin
         int src;
         bit obs;
         src = v;
         if ((sel == 3) && (dly3 == 2)) src = (v + 1 < NV) ? v + 1 : NV - 1;
         if (sel == 0) obs = stuck0 ? 1'b0 : (maj(src) ^ bad0[src]);
         else          obs = stuck3 ? 1'b0 : (maj(src) ^ bad3[src]);
         if (obs != maj(v)) begin
            cnt++;
            if (first < 0) first = v;
         end
      end
   endfunction

   task automatic clear_faults();
      for (int i = 0; i < NV; i++) begin
         bad0[i] = 1'b0;
         bad3[i] = 1'b0;
      end
      stuck0 = 1'b0;
      stuck3 = 1'b0;
      dly3   = 3;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".a_out0"}, 32'(bus0.a_out), 0);
      check({tag, ".busy0"},  32'(busy0), 0);
      check({tag, ".done0"},  32'(done0), 0);
      check({tag, ".pass0"},  32'(pass0), 0);
      check({tag, ".err0"},   32'(err0), 0);
      check({tag, ".ff0"},    32'(ff0), 0);
      check({tag, ".ffv0"},   32'(ffv0), 0);
      check({tag, ".a_out3"}, 32'(bus3.a_out), 0);
      check({tag, ".busy3"},  32'(busy3), 0);
      check({tag, ".done3"},  32'(done3), 0);
      check({tag, ".err3"},   32'(err3), 0);
      check({tag, ".ffv3"},   32'(ffv3), 0);
   endtask

   // One sweep on both instances. restart_at pulses start again mid-sweep
   // (must be ignored); rst_at pulls reset mid-sweep and abandons the sweep.
   task automatic run_sweep(input string name, input int restart_at, input int rst_at);
      int d0, d3, cyc, e_cnt, e_first;
      d0  = -1;
      d3  = -1;
      cyc = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      while (((d0 < 0) || (d3 < 0)) && (cyc < 700)) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start = (cyc == restart_at);
         if (cyc == 5) begin
            check({name, ".busy0_run"}, 32'(busy0), 1);
            check({name, ".pass0_clr"}, 32'(pass0), 0);
            check({name, ".a_out0_5"},  32'(bus0.a_out), 5);
            check({name, ".a_out3_5"},  32'(bus3.a_out), 5);
         end
         if (cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_zero({name, ".midrst"});
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (done0 && (d0 < 0)) d0 = cyc;
         if (done3 && (d3 < 0)) d3 = cyc;
      end
      start = 1'b0;
      check({name, ".done0_cyc"}, 32'(d0), NV);
      check({name, ".done3_cyc"}, 32'(d3), NV + 3);
      model(0, e_cnt, e_first);
      check({name, ".err0"},  32'(err0), 32'(e_cnt));
      check({name, ".ff0"},   32'(ff0),  (e_first < 0) ? 0 : 32'(e_first));
      check({name, ".ffv0"},  32'(ffv0), (e_first < 0) ? 0 : 1);
      check({name, ".pass0"}, 32'(pass0), (e_cnt == 0) ? 1 : 0);
      check({name, ".busy0"}, 32'(busy0), 0);
      model(3, e_cnt, e_first);
      check({name, ".err3"},  32'(err3), 32'(e_cnt));
      check({name, ".ff3"},   32'(ff3),  (e_first < 0) ? 0 : 32'(e_first));
      check({name, ".ffv3"},  32'(ffv3), (e_first < 0) ? 0 : 1);
      check({name, ".pass3"}, 32'(pass3), (e_cnt == 0) ? 1 : 0);
   endtask

   task automatic add_random_faults(input int sel, input int max_n);
      int k;
      k = $urandom_range(0, max_n);
      for (int i = 0; i < k; i++) begin
         if (sel == 0) bad0[$urandom_range(0, NV - 1)] = 1'b1;
         else          bad3[$urandom_range(0, NV - 1)] = 1'b1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      clear_faults();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Clean nets; a start pulse during RUN must not restart the sweep.
      run_sweep("clean", 50, 0);

      // Single inverted vector on the combinational net, random faults on the
      // pipelined one.
      clear_faults();
      bad0[9'h1F0] = 1'b1;
      add_random_faults(3, 3);
      run_sweep("inv1f0", 0, 0);
      check("inv1f0.err0_abs", 32'(err0), 1);
      check("inv1f0.ff0_abs",  32'(ff0), 32'h1F0);

      // Stuck-at-0 net, and a pipelined net one stage too short.
      clear_faults();
      stuck0 = 1'b1;
      dly3   = 2;
      run_sweep("stuck_dly2", 0, 0);
      check("stuck_dly2.err0_abs", 32'(err0), 256);
      check("stuck_dly2.ff0_abs",  32'(ff0), 32'h01F);
      check("stuck_dly2.err3_nz",  32'(err3 != 0), 1);

      // Randomised fault sets, some with a stray start pulse.
      for (int r = 0; r < 4; r++) begin
         clear_faults();
         add_random_faults(0, 5);
         add_random_faults(3, 5);
         run_sweep($sformatf("rand%0d", r), (r[0]) ? int'($urandom_range(10, 400)) : 0, 0);
      end

      // Reset at cycle 100 of RUN, then a clean sweep from scratch.
      clear_faults();
      bad0[9'h0AA] = 1'b1;
      run_sweep("abort", 0, 100);
      @(negedge clk);
      check("abort.idle_busy0", 32'(busy0), 0);
      check("abort.idle_done0", 32'(done0), 0);
      clear_faults();
      run_sweep("after_rst", 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
